// File: rtl/warp_issue_ctrl_pkg.sv
// Shared sizing, warp state encoding and id types for the warp issue controller.
package warp_issue_ctrl_pkg;

  localparam int unsigned NUM_WARPS_PER_SM = 4;
  localparam int unsigned NUM_WARPS        = NUM_WARPS_PER_SM;
  localparam int unsigned MAX_OUTSTAND     = 3;
  localparam int unsigned WID_W            = $clog2(NUM_WARPS);
  localparam int unsigned CNT_W            = $clog2(MAX_OUTSTAND + 1);

  typedef enum logic [1:0] {
    INACTIVE = 2'd0,
    ACTIVE   = 2'd1,
    BARRIER  = 2'd2,
    DRAIN    = 2'd3
  } warp_state_t;

  typedef logic [WID_W-1:0] warp_id_t;
  typedef logic [CNT_W-1:0] outst_cnt_t;

endpackage

// File: rtl/warp_issue_ctrl_if.sv
// Launch / instruction-buffer / arbiter / completion / issue signals of the warp issue controller.
interface warp_issue_ctrl_if;
  import warp_issue_ctrl_pkg::*;

  logic                 launch_valid;
  logic [NUM_WARPS-1:0] launch_mask;
  logic [NUM_WARPS-1:0] ibuf_valid;
  logic [NUM_WARPS-1:0] ibuf_is_barrier;
  logic [NUM_WARPS-1:0] ibuf_is_exit;
  logic                 stall;
  logic [NUM_WARPS-1:0] grantOH;
  logic                 complete_valid;
  warp_id_t             complete_wid;

  logic [NUM_WARPS-1:0] request;
  logic                 issue_valid;
  logic [NUM_WARPS-1:0] issue_oh;
  warp_id_t             issue_wid;
  logic [NUM_WARPS-1:0] warp_done_oh;
  logic [NUM_WARPS-1:0] active_mask;
  logic                 sm_idle;

  modport master (
    output launch_valid, launch_mask, ibuf_valid, ibuf_is_barrier, ibuf_is_exit,
           stall, grantOH, complete_valid, complete_wid,
    input  request, issue_valid, issue_oh, issue_wid, warp_done_oh, active_mask, sm_idle
  );

  modport slave (
    input  launch_valid, launch_mask, ibuf_valid, ibuf_is_barrier, ibuf_is_exit,
           stall, grantOH, complete_valid, complete_wid,
    output request, issue_valid, issue_oh, issue_wid, warp_done_oh, active_mask, sm_idle
  );

endinterface

// File: rtl/warp_issue_ctrl_warp_slot_fsm.sv
// One warp's lifecycle state and in-flight instruction counter.
module warp_slot_fsm
  import warp_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        launch_i,
  input  logic        issue_i,
  input  logic        is_barrier_i,
  input  logic        is_exit_i,
  input  logic        complete_i,
  input  logic        release_i,
  output warp_state_t state_o,
  output outst_cnt_t  outst_o,
  output logic        done_o
);

  warp_state_t state_q, state_d;
  outst_cnt_t  outst_q, outst_d;
  logic        done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INACTIVE;
      outst_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_d;
      done_q  <= done_d;
    end
  end

  // Same-cycle issue and retire cancel; a retire against an empty counter is dropped.
  always_comb begin
    state_d = state_q;
    outst_d = outst_q;
    done_d  = 1'b0;

    if (issue_i && !complete_i) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (complete_i && !issue_i && (outst_q != '0)) begin
      outst_d = outst_q - CNT_W'(1);
    end

    case (state_q)
      INACTIVE: if (launch_i) state_d = ACTIVE;
      ACTIVE: begin
        if (issue_i) begin
          if (is_exit_i)         state_d = DRAIN;
          else if (is_barrier_i) state_d = BARRIER;
        end
      end
      BARRIER: if (release_i) state_d = ACTIVE;
      DRAIN: begin
        if (outst_d == '0) begin
          state_d = INACTIVE;
          done_d  = 1'b1;
        end
      end
      default: state_d = INACTIVE;
    endcase
  end

  no_underflow_a: assert property (@(posedge clk) disable iff (reset)
    !(complete_i && !issue_i && (outst_q == '0)));

  assign state_o = state_q;
  assign outst_o = outst_q;
  assign done_o  = done_q;

endmodule

// File: rtl/warp_issue_ctrl.sv
// Requester side of the per-SM warp round-robin arbiter: request/grant qualification,
// barrier release and issue encoding around NUM_WARPS warp slot state machines.
module warp_issue_ctrl
  import warp_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  warp_issue_ctrl_if.slave  bus
);

  warp_state_t          state [NUM_WARPS];
  outst_cnt_t           outst [NUM_WARPS];
  logic [NUM_WARPS-1:0] done;
  logic [NUM_WARPS-1:0] is_inactive, is_active, is_barrier, is_drain;
  logic [NUM_WARPS-1:0] complete_hit;
  logic [NUM_WARPS-1:0] request_c, issue_oh_c;
  warp_id_t             issue_wid_c;
  logic                 release_c;
  logic                 any_outst_c;

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_slot
    warp_slot_fsm u_slot (
      .clk          (clk),
      .reset        (reset),
      .launch_i     (bus.launch_valid & bus.launch_mask[g]),
      .issue_i      (issue_oh_c[g]),
      .is_barrier_i (bus.ibuf_is_barrier[g]),
      .is_exit_i    (bus.ibuf_is_exit[g]),
      .complete_i   (complete_hit[g]),
      .release_i    (release_c),
      .state_o      (state[g]),
      .outst_o      (outst[g]),
      .done_o       (done[g])
    );
  end

  // Eligibility is purely from local state; the grant is only trusted where we asked.
  always_comb begin
    is_inactive  = '0;
    is_active    = '0;
    is_barrier   = '0;
    is_drain     = '0;
    complete_hit = '0;
    request_c    = '0;
    issue_wid_c  = '0;
    any_outst_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      is_inactive[i]  = (state[i] == INACTIVE);
      is_active[i]    = (state[i] == ACTIVE);
      is_barrier[i]   = (state[i] == BARRIER);
      is_drain[i]     = (state[i] == DRAIN);
      complete_hit[i] = bus.complete_valid && (bus.complete_wid == WID_W'(i));
      request_c[i]    = is_active[i] && bus.ibuf_valid[i] &&
                        (outst[i] < CNT_W'(MAX_OUTSTAND)) && !bus.stall;
      any_outst_c     = any_outst_c | (outst[i] != '0);
    end
    issue_oh_c = bus.grantOH & request_c;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (issue_oh_c[i]) issue_wid_c = WID_W'(i);
    end
  end

  // Draining warps never hold the barrier; release needs at least one waiter.
  assign release_c = (&(is_inactive | is_barrier | is_drain)) && (|is_barrier);

  assign bus.request      = request_c;
  assign bus.issue_oh     = issue_oh_c;
  assign bus.issue_valid  = |issue_oh_c;
  assign bus.issue_wid    = issue_wid_c;
  assign bus.warp_done_oh = done;
  assign bus.active_mask  = ~is_inactive;
  assign bus.sm_idle      = (&is_inactive) && !any_outst_c;

endmodule

// File: tb/tb_warp_issue_ctrl.sv
// Bench for warp_issue_ctrl: directed scenarios plus a random run against a warp-level model.
module tb_warp_issue_ctrl;
  import warp_issue_ctrl_pkg::*;

  localparam int MAXO    = 3;
  localparam int M_OFF   = 0;
  localparam int M_RUN   = 1;
  localparam int M_BAR   = 2;
  localparam int M_DRAIN = 3;

  logic clk;
  logic reset;
  warp_issue_ctrl_if bus();

  warp_issue_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Round-robin arbiter environment: returns 0001 when nothing is requested.
  logic [3:0] arb_last;

  function automatic logic [3:0] rr_grant(input logic [3:0] req, input logic [3:0] last);
    int li;
    int j;
    li = 0;
    for (int k = 0; k < 4; k++) if (last[k]) li = k;
    for (int k = 1; k <= 4; k++) begin
      j = (li + k) % 4;
      if (req[j]) return 4'b0001 << j;
    end
    return 4'b0001;
  endfunction

  always_comb bus.grantOH = rr_grant(bus.request, arb_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) arb_last <= 4'b0001;
    else if (|bus.request) arb_last <= bus.grantOH;
  end

  // Warp-level reference model.
  int         ms [4];
  int         mo [4];
  logic [3:0] mdone;
  logic [3:0] exp_req, exp_issue, exp_active;
  logic [1:0] exp_wid;
  logic       exp_idle;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ms[i] = M_OFF;
      mo[i] = 0;
    end
    mdone = '0;
  endtask

  function automatic int model_n_run();
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (ms[i] == M_RUN) n++;
    return n;
  endfunction

  task automatic eval_exp();
    exp_idle = 1'b1;
    exp_wid  = '0;
    for (int i = 0; i < 4; i++) begin
      exp_req[i]    = (ms[i] == M_RUN) && bus.ibuf_valid[i] && (mo[i] < MAXO) && !bus.stall;
      exp_active[i] = (ms[i] != M_OFF);
      if (ms[i] != M_OFF || mo[i] != 0) exp_idle = 1'b0;
    end
    exp_issue = exp_req & rr_grant(exp_req, arb_last);
    for (int i = 0; i < 4; i++) if (exp_issue[i]) exp_wid = 2'(i);
  endtask

  task automatic model_update();
    bit rel;
    bit iss;
    bit cmp;
    int nbar;
    nbar = 0;
    for (int i = 0; i < 4; i++) if (ms[i] == M_BAR) nbar++;
    rel   = (model_n_run() == 0) && (nbar > 0);
    mdone = '0;
    for (int i = 0; i < 4; i++) begin
      iss = exp_issue[i];
      cmp = bus.complete_valid && (bus.complete_wid == 2'(i));
      if (!(iss && cmp)) begin
        if (iss) mo[i]++;
        else if (cmp && mo[i] > 0) mo[i]--;
      end
      case (ms[i])
        M_OFF:   if (bus.launch_valid && bus.launch_mask[i]) ms[i] = M_RUN;
        M_RUN:   if (iss) ms[i] = bus.ibuf_is_exit[i] ? M_DRAIN :
                                  (bus.ibuf_is_barrier[i] ? M_BAR : M_RUN);
        M_BAR:   if (rel) ms[i] = M_RUN;
        default: if (mo[i] == 0) begin ms[i] = M_OFF; mdone[i] = 1'b1; end
      endcase
    end
  endtask

  task automatic clear_inputs();
    bus.launch_valid    = 1'b0;
    bus.launch_mask     = '0;
    bus.ibuf_valid      = '0;
    bus.ibuf_is_barrier = '0;
    bus.ibuf_is_exit    = '0;
    bus.stall           = 1'b0;
    bus.complete_valid  = 1'b0;
    bus.complete_wid    = '0;
  endtask

  task automatic settle();
    #1;
    eval_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic launch(input logic [3:0] m);
    bus.launch_valid = 1'b1;
    bus.launch_mask  = m;
    settle();
    tick();
    bus.launch_valid = 1'b0;
    bus.launch_mask  = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    n_vec++; if (bus.request !== 4'b0000)     begin n_err++; $display("FAIL reset_request got=%b exp=0000", bus.request); end
    n_vec++; if (bus.issue_valid !== 1'b0)    begin n_err++; $display("FAIL reset_issue_valid got=%b exp=0", bus.issue_valid); end
    n_vec++; if (bus.issue_oh !== 4'b0000)    begin n_err++; $display("FAIL reset_issue_oh got=%b exp=0000", bus.issue_oh); end
    n_vec++; if (bus.issue_wid !== 2'd0)      begin n_err++; $display("FAIL reset_issue_wid got=%0d exp=0", bus.issue_wid); end
    n_vec++; if (bus.warp_done_oh !== 4'b0000) begin n_err++; $display("FAIL reset_done got=%b exp=0000", bus.warp_done_oh); end
    n_vec++; if (bus.active_mask !== 4'b0000) begin n_err++; $display("FAIL reset_active got=%b exp=0000", bus.active_mask); end
    n_vec++; if (bus.sm_idle !== 1'b1)        begin n_err++; $display("FAIL reset_idle got=%b exp=1", bus.sm_idle); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] seq [4];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    launch(4'b1111);
    bus.ibuf_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_vec++; if (bus.request !== 4'b1111) begin n_err++; $display("FAIL rot_request k=%0d got=%b exp=1111", k, bus.request); end
      n_vec++; if (bus.issue_oh !== seq[k]) begin n_err++; $display("FAIL rot_issue k=%0d got=%b exp=%b", k, bus.issue_oh, seq[k]); end
      tick();
    end
    settle();
    n_vec++; if (bus.active_mask !== 4'b1111) begin n_err++; $display("FAIL rot_active got=%b exp=1111", bus.active_mask); end
  endtask

  task automatic test_outstanding_limit();
    do_reset();
    launch(4'b0100);
    bus.ibuf_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_vec++; if (bus.issue_oh !== 4'b0100) begin n_err++; $display("FAIL lim_issue k=%0d got=%b exp=0100", k, bus.issue_oh); end
      tick();
    end
    settle();
    n_vec++; if (bus.request !== 4'b0000) begin n_err++; $display("FAIL lim_full got=%b exp=0000", bus.request); end
    n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL lim_issue_valid got=%b exp=0", bus.issue_valid); end
    bus.complete_valid = 1'b1;
    bus.complete_wid   = 2'd2;
    settle();
    n_vec++; if (bus.request !== 4'b0000) begin n_err++; $display("FAIL lim_same_cycle got=%b exp=0000", bus.request); end
    tick();
    bus.complete_valid = 1'b0;
    settle();
    n_vec++; if (bus.request !== 4'b0100) begin n_err++; $display("FAIL lim_reopen got=%b exp=0100", bus.request); end
    tick();
  endtask

  task automatic test_unqualified_grant();
    do_reset();
    launch(4'b0001);
    for (int k = 0; k < 4; k++) begin
      settle();
      n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL unq_issue_valid k=%0d got=%b exp=0", k, bus.issue_valid); end
      n_vec++; if (bus.issue_oh !== 4'b0000) begin n_err++; $display("FAIL unq_issue_oh k=%0d got=%b exp=0000", k, bus.issue_oh); end
      tick();
    end
    bus.stall      = 1'b1;
    bus.ibuf_valid = 4'b0001;
    settle();
    n_vec++; if (bus.request !== 4'b0000) begin n_err++; $display("FAIL stall_request got=%b exp=0000", bus.request); end
    tick();
    bus.stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_vec++; if (bus.issue_oh !== 4'b0001) begin n_err++; $display("FAIL unq_count k=%0d got=%b exp=0001", k, bus.issue_oh); end
      tick();
    end
    settle();
    n_vec++; if (bus.request !== 4'b0000) begin n_err++; $display("FAIL unq_full got=%b exp=0000", bus.request); end
  endtask

  task automatic test_barrier();
    bit reached;
    do_reset();
    launch(4'b1111);
    bus.ibuf_valid      = 4'b0011;
    bus.ibuf_is_barrier = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      settle();
      tick();
    end
    bus.ibuf_valid      = 4'b1111;
    bus.ibuf_is_barrier = 4'b0000;
    settle();
    n_vec++; if (bus.request !== 4'b1100) begin n_err++; $display("FAIL bar_blocked got=%b exp=1100", bus.request); end
    tick();
    bus.ibuf_is_barrier = 4'b1111;
    reached = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (model_n_run() == 0) begin
        reached = 1'b1;
        break;
      end
      n_vec++; if (bus.request !== exp_req) begin n_err++; $display("FAIL bar_request k=%0d got=%b exp=%b", k, bus.request, exp_req); end
      tick();
    end
    n_vec++; if (!reached) begin n_err++; $display("FAIL bar_timeout got=running exp=all_waiting"); end
    n_vec++; if (bus.request !== 4'b0000) begin n_err++; $display("FAIL bar_all_wait got=%b exp=0000", bus.request); end
    n_vec++; if (bus.active_mask !== 4'b1111) begin n_err++; $display("FAIL bar_active got=%b exp=1111", bus.active_mask); end
    tick();
    bus.ibuf_is_barrier = 4'b0000;
    settle();
    n_vec++; if (bus.request !== 4'b1111) begin n_err++; $display("FAIL bar_release got=%b exp=1111", bus.request); end
  endtask

  task automatic test_exit_drain();
    do_reset();
    launch(4'b1000);
    bus.ibuf_valid = 4'b1000;
    settle();
    n_vec++; if (bus.issue_oh !== 4'b1000) begin n_err++; $display("FAIL exit_first got=%b exp=1000", bus.issue_oh); end
    tick();
    bus.ibuf_is_exit = 4'b1000;
    settle();
    n_vec++; if (bus.issue_wid !== 2'd3) begin n_err++; $display("FAIL exit_wid got=%0d exp=3", bus.issue_wid); end
    tick();
    bus.ibuf_valid   = 4'b0000;
    bus.ibuf_is_exit = 4'b0000;
    settle();
    n_vec++; if (bus.active_mask !== 4'b1000) begin n_err++; $display("FAIL drain_active got=%b exp=1000", bus.active_mask); end
    n_vec++; if (bus.sm_idle !== 1'b0) begin n_err++; $display("FAIL drain_idle got=%b exp=0", bus.sm_idle); end
    bus.complete_valid = 1'b1;
    bus.complete_wid   = 2'd3;
    tick();
    bus.launch_valid = 1'b1;
    bus.launch_mask  = 4'b1000;
    settle();
    n_vec++; if (bus.warp_done_oh !== 4'b0000) begin n_err++; $display("FAIL drain_early_done got=%b exp=0000", bus.warp_done_oh); end
    tick();
    clear_inputs();
    settle();
    n_vec++; if (bus.warp_done_oh !== 4'b1000) begin n_err++; $display("FAIL drain_done got=%b exp=1000", bus.warp_done_oh); end
    n_vec++; if (bus.active_mask !== 4'b0000) begin n_err++; $display("FAIL drain_launch_ignored got=%b exp=0000", bus.active_mask); end
    n_vec++; if (bus.sm_idle !== 1'b1) begin n_err++; $display("FAIL drain_idle_end got=%b exp=1", bus.sm_idle); end
    tick();
    settle();
    n_vec++; if (bus.warp_done_oh !== 4'b0000) begin n_err++; $display("FAIL drain_done_once got=%b exp=0000", bus.warp_done_oh); end
  endtask

  task automatic test_same_cycle_and_reset();
    do_reset();
    launch(4'b0010);
    bus.ibuf_valid = 4'b0010;
    settle();
    tick();
    bus.complete_valid = 1'b1;
    bus.complete_wid   = 2'd1;
    settle();
    n_vec++; if (bus.issue_oh !== 4'b0010) begin n_err++; $display("FAIL same_issue got=%b exp=0010", bus.issue_oh); end
    tick();
    bus.complete_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_vec++; if (bus.issue_oh !== 4'b0010) begin n_err++; $display("FAIL same_after k=%0d got=%b exp=0010", k, bus.issue_oh); end
      tick();
    end
    settle();
    n_vec++; if (bus.request !== 4'b0000) begin n_err++; $display("FAIL same_full got=%b exp=0000", bus.request); end
    launch(4'b1111);
    bus.ibuf_valid = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (bus.request !== 4'b0000) begin n_err++; $display("FAIL midrst_request got=%b exp=0000", bus.request); end
    n_vec++; if (bus.issue_valid !== 1'b0) begin n_err++; $display("FAIL midrst_issue got=%b exp=0", bus.issue_valid); end
    n_vec++; if (bus.active_mask !== 4'b0000) begin n_err++; $display("FAIL midrst_active got=%b exp=0000", bus.active_mask); end
    n_vec++; if (bus.sm_idle !== 1'b1) begin n_err++; $display("FAIL midrst_idle got=%b exp=1", bus.sm_idle); end
    n_vec++; if (bus.warp_done_oh !== 4'b0000) begin n_err++; $display("FAIL midrst_done got=%b exp=0000", bus.warp_done_oh); end
    clear_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int cand [$];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.launch_valid = ($urandom_range(0, 5) == 0);
      bus.launch_mask  = 4'($urandom);
      bus.ibuf_valid   = 4'($urandom);
      bus.stall        = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 4; i++) begin
        bus.ibuf_is_barrier[i] = ($urandom_range(0, 7) == 0);
        bus.ibuf_is_exit[i]    = ($urandom_range(0, 15) == 0);
      end
      cand.delete();
      for (int i = 0; i < 4; i++) if (mo[i] > 0) cand.push_back(i);
      bus.complete_valid = 1'b0;
      bus.complete_wid   = '0;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.complete_valid = 1'b1;
        bus.complete_wid   = 2'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      settle();
      n_vec++; if (bus.request !== exp_req)         begin n_err++; $display("FAIL rnd_request c=%0d got=%b exp=%b", c, bus.request, exp_req); end
      n_vec++; if (bus.issue_oh !== exp_issue)      begin n_err++; $display("FAIL rnd_issue_oh c=%0d got=%b exp=%b", c, bus.issue_oh, exp_issue); end
      n_vec++; if (bus.issue_valid !== (|exp_issue)) begin n_err++; $display("FAIL rnd_issue_valid c=%0d got=%b exp=%b", c, bus.issue_valid, |exp_issue); end
      n_vec++; if (bus.issue_wid !== exp_wid)       begin n_err++; $display("FAIL rnd_issue_wid c=%0d got=%0d exp=%0d", c, bus.issue_wid, exp_wid); end
      n_vec++; if (bus.warp_done_oh !== mdone)      begin n_err++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, bus.warp_done_oh, mdone); end
      n_vec++; if (bus.active_mask !== exp_active)  begin n_err++; $display("FAIL rnd_active c=%0d got=%b exp=%b", c, bus.active_mask, exp_active); end
      n_vec++; if (bus.sm_idle !== exp_idle)        begin n_err++; $display("FAIL rnd_idle c=%0d got=%b exp=%b", c, bus.sm_idle, exp_idle); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_rotation();
    test_outstanding_limit();
    test_unqualified_grant();
    test_barrier();
    test_exit_drain();
    test_same_cycle_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
